serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: requests an addition of a and b.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, sampled only on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, sampled only on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the result becomes valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the registered result, held until the next completion.
REQ-010 The block SHALL have port carry, output, 1 bit: the registered carry out of the MSB, held with sum.

Function
REQ-011 The datapath SHALL be one 1-bit full adder built from two half-adder cells plus an OR gate, reused once per bit, LSB first.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; reset SHALL force IDLE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL be accepted with the following effects:
- a and b are captured into internal shift registers.
- The internal carry register is cleared.
- The bit counter is set to 0.
- The FSM moves to RUN.
REQ-014 In RUN, each rising edge SHALL perform one bit-step:
- The adder is applied to the shift-register LSBs and the carry register.
- The sum bit is shifted into the result shift register at the MSB end.
- The carry register is updated.
- The counter is incremented.
REQ-015 On the edge that completes bit WIDTH-1, the FSM SHALL move to DONE and load sum and carry from the internal registers on that same edge.
REQ-016 DONE SHALL last exactly one cycle; without an accepted start the FSM SHALL return to IDLE.
REQ-017 Latency: if start is accepted at edge E0, done SHALL be high in the cycle following edge E(WIDTH), and low at all other times.
REQ-018 busy SHALL be high exactly while the state is RUN.
REQ-019 start asserted while the state is RUN SHALL be ignored: no operand capture, no queuing, and no effect on the result.
REQ-020 start accepted in DONE SHALL begin a new operation with no idle cycle; done still pulses for the completing operation.
REQ-021 sum and carry SHALL change only at the DONE-entry edge or at reset; they SHALL be stable during RUN.
REQ-022 The result SHALL be the modulo 2^WIDTH sum of a and b, with carry equal to bit WIDTH of the full-precision sum.
REQ-023 Counter wrap-around SHALL NOT occur; the counter SHALL be held at 0 outside RUN.

Reset
REQ-024 rst_n=0 SHALL, asynchronously and at any time including mid-RUN, drive the following to zero:
- The state (to IDLE).
- busy, done, sum and carry.
- The counter, the carry register and the shift registers.
REQ-025 An operation interrupted by reset SHALL be abandoned with no done pulse.
REQ-026 After rst_n deasserts, the first start SHALL be accepted at the first rising edge at which it is sampled high.

Configuration
REQ-027 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add port ovf, output, 1 bit.
- ovf flags two's-complement overflow: the carry into the MSB XOR the carry out of the MSB.
- ovf is registered with sum, reset to 0, and held like sum.
REQ-028 With SERIAL_ADDER_OVF_EN undefined, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover these directed scenarios at WIDTH=8:
- Case 1: start with a=8'h03, b=8'h05 -> sum=8'h08, carry=0; done high exactly in the cycle after the 8th edge following acceptance; busy high for 8 cycles.
- Case 2: a=8'hFF, b=8'h01 -> sum=8'h00, carry=1, ovf=0.
- Case 3 (macro defined): a=8'h7F, b=8'h01 -> sum=8'h80, carry=0, ovf=1; and a=8'h80, b=8'h80 -> sum=8'h00, carry=1, ovf=1.
- Case 4: start a=8'h10, b=8'h20, then start a=8'hFF, b=8'hFF on the 3rd RUN cycle -> second request ignored; sum=8'h30, carry=0; exactly one done pulse.
- Case 5: rst_n pulsed low during the 4th RUN cycle of a=8'hAA, b=8'h55 -> busy, done, sum and carry are 0 immediately; no done pulse follows; a following start with a=8'h01, b=8'h01 gives sum=8'h02.
- Case 6: start held high continuously with a=8'h01, b=8'h02 -> done pulses every 9 cycles; sum=8'h03 after each pulse; no idle cycle between operations.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : serial_adder_ctrl                                          |
// | Description : Bit-serial adder. One full adder (two half-adder cells     |
// |               plus an OR gate) is reused once per bit, LSB first, under  |
// |               an IDLE/RUN/DONE controller. A result takes WIDTH cycles   |
// |               in RUN followed by a one-cycle DONE.                       |
// | Config      : `define SERIAL_ADDER_OVF_EN adds the ovf output            |
// |               (two's-complement overflow, registered with sum).          |
// | Ports       : clk    - clock, rising edge                                |
// |               rst_n  - asynchronous active-low reset                     |
// |               start  - request an addition (ignored while busy)          |
// |               a, b   - operands, captured on an accepted start           |
// |               busy   - high while the state is RUN                       |
// |               done   - one-cycle pulse when sum/carry become valid       |
// |               sum    - registered result, held until next completion     |
// |               carry  - registered carry out of the MSB                   |
// |               ovf    - (optional) signed overflow, held with sum         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            C_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Holds the WIDTH-1 sum bits already produced; the final bit comes
    // straight from the adder on the completing edge.
    logic [WIDTH-2:0] r_res_sh;
    logic [WIDTH-2:0] w_res_shifted;
    logic             r_c;
    logic [C_CW-1:0]  r_cnt;

    logic w_accept;
    logic w_last;

    // Full adder: two half-adder cells plus an OR gate.
    logic w_ha0_s;
    logic w_ha0_c;
    logic w_fa_s;
    logic w_ha1_c;
    logic w_fa_co;

    assign w_ha0_s = r_a_sh[0] ^ r_b_sh[0];
    assign w_ha0_c = r_a_sh[0] & r_b_sh[0];
    assign w_fa_s  = w_ha0_s ^ r_c;
    assign w_ha1_c = w_ha0_s & r_c;
    assign w_fa_co = w_ha0_c | w_ha1_c;

    assign w_last = (r_cnt == C_LAST);

    // New sum bits enter at the MSB of the partial-result register.
    generate
        if (WIDTH == 2) begin : g_res_narrow
            assign w_res_shifted = w_fa_s;
        end else begin : g_res_wide
            assign w_res_shifted = {w_fa_s, r_res_sh[WIDTH-2:1]};
        end
    endgenerate

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next-state and outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start here chains straight into the next operation.
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            carry    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_c    <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_shifted;
            r_c      <= w_fa_co;
            if (w_last) begin
                // Counter parks at 0 so it never wraps outside RUN.
                r_cnt <= '0;
                sum   <= {w_fa_s, r_res_sh};
                carry <= w_fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                // r_c is the carry into the MSB at this step.
                ovf   <= r_c ^ w_fa_co;
`endif
            end else begin
                r_cnt <= r_cnt + C_CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_adder_ctrl                                       |
// | Description : Self-checking bench for serial_adder_ctrl at WIDTH=8.      |
// |               Table-driven operand vectors plus hand-written sequences   |
// |               for ignored start, mid-run reset and back-to-back starts.  |
// | Config      : honours `define SERIAL_ADDER_OVF_EN for the ovf checks.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_serial_adder_ctrl;

    localparam int C_W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [C_W-1:0] a;
    logic [C_W-1:0] b;
    logic           busy;
    logic           done;
    logic [C_W-1:0] sum;
    logic           carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic           ovf;
`endif

    serial_adder_ctrl #(.WIDTH(C_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[8];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic cur_ovf();
`ifdef SERIAL_ADDER_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         output int lat, output int bcnt, output int unstable);
        logic [7:0] prev;
        prev = sum;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        bcnt     = 0;
        unstable = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            if (sum !== prev) unstable++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, unstable, cnt, pulses, last_idx, idle;

        vecs[0] = '{8'h03, 8'h05, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'h7F, 8'hFE, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy",  32'(busy),  32'h0);
        chk("reset_done",  32'(done),  32'h0);
        chk("reset_sum",   32'(sum),   32'h0);
        chk("reset_carry", 32'(carry), 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("reset_ovf",   32'(ovf),   32'h0);
`endif
        rst_n = 1'b1;

        // Table-driven operand vectors.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, bcnt, unstable);
            chk($sformatf("v%0d_latency", i),  32'(lat),      32'd8);
            chk($sformatf("v%0d_busy_cyc", i), 32'(bcnt),     32'd8);
            chk($sformatf("v%0d_sum_hold", i), 32'(unstable), 32'd0);
            chk($sformatf("v%0d_sum", i),      32'(sum),      32'(vecs[i].s));
            chk($sformatf("v%0d_carry", i),    32'(carry),    32'(vecs[i].c));
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("v%0d_ovf", i),      32'(cur_ovf()), 32'(vecs[i].v));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_once", i), 32'(done), 32'h0);
        end

        // Reset during the 4th RUN cycle of AA+55; prior result is FE/1.
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_done",  32'(done),  32'h0);
        chk("rst_sum",   32'(sum),   32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf",   32'(cur_ovf()), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cnt   = 0;
        idle  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) cnt++;
            if (busy) idle++;
        end
        chk("rst_no_done", 32'(cnt),  32'd0);
        chk("rst_no_busy", 32'(idle), 32'd0);
        do_op(8'h01, 8'h01, lat, bcnt, unstable);
        chk("post_rst_latency", 32'(lat),   32'd8);
        chk("post_rst_sum",     32'(sum),   32'h02);
        chk("post_rst_carry",   32'(carry), 32'h0);

        // Start during the 3rd RUN cycle is ignored.
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        for (int i = 1; i < 24; i++) begin
            if (i == 3) begin
                a     = 8'hFF;
                b     = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                cnt++;
                chk("ign_sum_at_done", 32'(sum), 32'h30);
            end
            @(negedge clk);
        end
        chk("ign_done_count", 32'(cnt),   32'd1);
        chk("ign_sum",        32'(sum),   32'h30);
        chk("ign_carry",      32'(carry), 32'h0);

        // Start held high: done every 9 cycles, no idle cycle in between.
        @(negedge clk);
        a        = 8'h01;
        b        = 8'h02;
        start    = 1'b1;
        pulses   = 0;
        last_idx = -1;
        idle     = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy && !done) idle++;
            if (done) begin
                pulses++;
                chk("b2b_sum", 32'(sum), 32'h03);
                if (last_idx < 0) chk("b2b_first_lat", 32'(i), 32'd8);
                else              chk("b2b_period",    32'(i - last_idx), 32'd9);
                last_idx = i;
            end
        end
        start = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_idle",   32'(idle),   32'd0);
        cnt = 0;
        while (busy && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
